// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave CSR bank of NUM_REGS words.
// Write address and data are captured independently and committed together.
// Commits honour byte strobes. Read-only slots are served from reg_in.
// Each committed write to a register raises a one-cycle pulse for that register.
//
// Write response FSM
//   state   | meaning
//   B_IDLE  | no response pending; a held AW+W pair may commit
//   B_RESP  | bvalid high, bresp held until bready
//
// Read data FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for an address
//   R_DATA  | rvalid high, rdata/rresp held until rready
module axil_reg_bank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                           clk,
  input  logic                           resetn,
  // write address
  input  logic [ADDR_WIDTH-1:0]          axi_awaddr,
  input  logic [2:0]                     axi_awprot,
  input  logic                           axi_awvalid,
  output logic                           axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]          axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        axi_wstrb,
  input  logic                           axi_wvalid,
  output logic                           axi_wready,
  // write response
  output logic [1:0]                     axi_bresp,
  output logic                           axi_bvalid,
  input  logic                           axi_bready,
  // read address
  input  logic [ADDR_WIDTH-1:0]          axi_araddr,
  input  logic [2:0]                     axi_arprot,
  input  logic                           axi_arvalid,
  output logic                           axi_arready,
  // read data
  output logic [DATA_WIDTH-1:0]          axi_rdata,
  output logic [1:0]                     axi_rresp,
  output logic                           axi_rvalid,
  input  logic                           axi_rready,
  // register side
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {B_IDLE, B_RESP} b_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  b_state_t b_state, b_state_nxt;
  r_state_t r_state, r_state_nxt;

  // write holding registers
  logic                  aw_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  // write decode
  logic [ADDR_WIDTH-1:0] aw_word;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_in_range;
  logic                  wr_ok;
  logic                  commit;

  // read decode
  logic [ADDR_WIDTH-1:0] ar_word;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic                  ar_hs;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic [1:0]            rd_resp_c;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  // prot fields carry no meaning for this bank; reg_in slices of RW regs are never read
  logic unused_inputs;
  assign unused_inputs = ^{axi_awprot, axi_arprot, reg_in};

  assign aw_word     = aw_addr_q >> ADDR_LSB;
  assign aw_idx      = aw_word[IDX_W-1:0];
  assign aw_in_range = (aw_word < ADDR_WIDTH'(NUM_REGS));
  assign wr_ok       = aw_in_range && !RO_MASK[aw_idx];

  // a second AW+W pair may sit in the holding regs while a response is still pending
  assign commit = aw_held && w_held && (b_state == B_IDLE);

  assign ar_word     = axi_araddr >> ADDR_LSB;
  assign ar_idx      = ar_word[IDX_W-1:0];
  assign ar_in_range = (ar_word < ADDR_WIDTH'(NUM_REGS));
  assign ar_hs       = axi_arvalid && axi_arready;

  assign axi_awready = !aw_held;
  assign axi_wready  = !w_held;
  assign axi_bvalid  = (b_state == B_RESP);
  assign axi_bresp   = bresp_q;
  assign axi_arready = (r_state == R_IDLE);
  assign axi_rvalid  = (r_state == R_DATA);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

  // write address holding register: filled on handshake, emptied by commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
    end else if (axi_awvalid && !aw_held) begin
      aw_held   <= 1'b1;
      aw_addr_q <= axi_awaddr;
    end else if (commit) begin
      aw_held   <= 1'b0;
    end
  end

  // write data holding register: filled on handshake, emptied by commit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (axi_wvalid && !w_held) begin
      w_held   <= 1'b1;
      w_data_q <= axi_wdata;
      w_strb_q <= axi_wstrb;
    end else if (commit) begin
      w_held   <= 1'b0;
    end
  end

  // write response FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) b_state <= B_IDLE;
    else         b_state <= b_state_nxt;
  end

  // write response FSM next state
  always_comb begin
    b_state_nxt = b_state;
    case (b_state)
      B_IDLE:  if (commit)     b_state_nxt = B_RESP;
      B_RESP:  if (axi_bready) b_state_nxt = B_IDLE;
      default:                 b_state_nxt = B_IDLE;
    endcase
  end

  // response code is fixed at commit and held for the whole B phase
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     bresp_q <= RESP_OKAY;
    else if (commit) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
  end

  // register storage with byte-lane update; rejected writes leave it untouched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else if (commit && wr_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (w_strb_q[b]) regs_q[aw_idx][b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  // one-cycle strobe per accepted write, aligned with bvalid rising
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit && wr_ok) wr_pulse_q[aw_idx] <= 1'b1;
    end
  end

  // read source select; sampled at the AR handshake, so a same-edge commit is not visible
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_SLVERR;
    if (ar_in_range) begin
      rd_resp_c = RESP_OKAY;
      if (RO_MASK[ar_idx]) rd_data_c = reg_in[ar_idx*DATA_WIDTH +: DATA_WIDTH];
      else                 rd_data_c = regs_q[ar_idx];
    end
  end

  // read data FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= R_IDLE;
    else         r_state <= r_state_nxt;
  end

  // read data FSM next state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (axi_arvalid) r_state_nxt = R_DATA;
      R_DATA:  if (axi_rready)  r_state_nxt = R_IDLE;
      default:                  r_state_nxt = R_IDLE;
    endcase
  end

  // read data/response capture, held stable while rvalid waits for rready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data_c;
      rresp_q <= rd_resp_c;
    end
  end

  // read-only slots expose zero on reg_out since their storage is never written
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_out
    if (RO_MASK[gi]) begin : g_ro
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_rw
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: directed checks of the AXI4-Lite register bank.
module tb_axil_reg_bank;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'h0008;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [AW-1:0]    axi_awaddr;
  logic [2:0]       axi_awprot;
  logic             axi_awvalid;
  logic             axi_awready;
  logic [DW-1:0]    axi_wdata;
  logic [DW/8-1:0]  axi_wstrb;
  logic             axi_wvalid;
  logic             axi_wready;
  logic [1:0]       axi_bresp;
  logic             axi_bvalid;
  logic             axi_bready;
  logic [AW-1:0]    axi_araddr;
  logic [2:0]       axi_arprot;
  logic             axi_arvalid;
  logic             axi_arready;
  logic [DW-1:0]    axi_rdata;
  logic [1:0]       axi_rresp;
  logic             axi_rvalid;
  logic             axi_rready;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in;
  logic [NR-1:0]    wr_pulse;

  axil_reg_bank #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR),
    .RO_MASK   (RO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .axi_awaddr (axi_awaddr),
    .axi_awprot (axi_awprot),
    .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata  (axi_wdata),
    .axi_wstrb  (axi_wstrb),
    .axi_wvalid (axi_wvalid),
    .axi_wready (axi_wready),
    .axi_bresp  (axi_bresp),
    .axi_bvalid (axi_bvalid),
    .axi_bready (axi_bready),
    .axi_araddr (axi_araddr),
    .axi_arprot (axi_arprot),
    .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata  (axi_rdata),
    .axi_rresp  (axi_rresp),
    .axi_rvalid (axi_rvalid),
    .axi_rready (axi_rready),
    .reg_out    (reg_out),
    .reg_in     (reg_in),
    .wr_pulse   (wr_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_reg [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg_out%0d", tag, i), 64'(reg_out[i*DW +: DW]), 64'(exp_reg[i]));
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [NR-1:0] pulse);
    bit aw_pend, w_pend, aw_fire, w_fire, got_b;
    int c;
    axi_awaddr  = addr;
    axi_wdata   = data;
    axi_wstrb   = strb;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    c = 0;
    while ((aw_pend || w_pend) && c < 20) begin
      aw_fire = axi_awvalid && axi_awready;
      w_fire  = axi_wvalid && axi_wready;
      tick();
      if (aw_fire) begin axi_awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin axi_wvalid  = 1'b0; w_pend  = 1'b0; end
      c++;
    end
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    chk("wr_accept_timeout", 64'({aw_pend, w_pend}), 64'h0);
    resp  = 2'bxx;
    pulse = '0;
    got_b = 1'b0;
    c = 0;
    axi_bready = 1'b1;
    while (!got_b && c < 20) begin
      if (axi_bvalid) begin
        got_b = 1'b1;
        resp  = axi_bresp;
        pulse = wr_pulse;
      end
      tick();
      c++;
    end
    axi_bready = 1'b0;
    chk("wr_b_timeout", 64'(got_b), 64'h1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_pend, ar_fire, got_r;
    int c;
    axi_araddr  = addr;
    axi_arvalid = 1'b1;
    ar_pend = 1'b1;
    c = 0;
    while (ar_pend && c < 20) begin
      ar_fire = axi_arready;
      tick();
      if (ar_fire) begin axi_arvalid = 1'b0; ar_pend = 1'b0; end
      c++;
    end
    axi_arvalid = 1'b0;
    chk("rd_accept_timeout", 64'(ar_pend), 64'h0);
    data  = 'x;
    resp  = 'x;
    got_r = 1'b0;
    c = 0;
    axi_rready = 1'b1;
    while (!got_r && c < 20) begin
      if (axi_rvalid) begin
        got_r = 1'b1;
        data  = axi_rdata;
        resp  = axi_rresp;
      end
      tick();
      c++;
    end
    axi_rready = 1'b0;
    chk("rd_r_timeout", 64'(got_r), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0]   rd;
    logic [1:0]    rr;
    logic [1:0]    br;
    logic [NR-1:0] pl;
    int            c;
    bit            got;

    axi_awaddr = '0; axi_awprot = '0; axi_awvalid = 1'b0;
    axi_wdata  = '0; axi_wstrb  = '0; axi_wvalid  = 1'b0;
    axi_bready = 1'b0;
    axi_araddr = '0; axi_arprot = '0; axi_arvalid = 1'b0;
    axi_rready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      reg_in[i*DW +: DW] = (i == 3) ? 32'hCAFE0000 : 32'h5555AAAA;
      exp_reg[i] = '0;
    end

    // 1. reset state and read of every slot
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    chk("rst_awready", 64'(axi_awready), 64'h1);
    chk("rst_wready",  64'(axi_wready),  64'h1);
    chk("rst_arready", 64'(axi_arready), 64'h1);
    chk("rst_bvalid",  64'(axi_bvalid),  64'h0);
    chk("rst_rvalid",  64'(axi_rvalid),  64'h0);
    chk("rst_bresp",   64'(axi_bresp),   64'h0);
    chk("rst_rresp",   64'(axi_rresp),   64'h0);
    chk("rst_rdata",   64'(axi_rdata),   64'h0);
    chk("rst_wr_pulse", 64'(wr_pulse),   64'h0);
    check_bank("rst");
    for (int i = 0; i < NR; i++) begin
      axi_read(32'(i*4), rd, rr);
      chk($sformatf("t1_rdata%0d", i), 64'(rd), (i == 3) ? 64'hCAFE0000 : 64'h0);
      chk($sformatf("t1_rresp%0d", i), 64'(rr), 64'h0);
    end

    // 2. AW two cycles ahead of W
    axi_awaddr  = 32'h08;
    axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    chk("t2_awready_held", 64'(axi_awready), 64'h0);
    tick();
    chk("t2_bvalid_pre_w", 64'(axi_bvalid), 64'h0);
    axi_wdata  = 32'hDEADBEEF;
    axi_wstrb  = 4'hF;
    axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    chk("t2_bvalid_at_w", 64'(axi_bvalid), 64'h0);
    chk("t2_reg2_old", 64'(reg_out[2*DW +: DW]), 64'h0);
    tick();
    chk("t2_bvalid", 64'(axi_bvalid), 64'h1);
    chk("t2_bresp",  64'(axi_bresp),  64'h0);
    chk("t2_reg2",   64'(reg_out[2*DW +: DW]), 64'hDEADBEEF);
    chk("t2_pulse",  64'(wr_pulse), 64'h0004);
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
    chk("t2_bvalid_done", 64'(axi_bvalid), 64'h0);
    chk("t2_pulse_off",   64'(wr_pulse),   64'h0);
    exp_reg[2] = 32'hDEADBEEF;

    // 3. partial strobe write
    axi_write(32'h08, 32'h11223344, 4'b0101, br, pl);
    chk("t3_bresp", 64'(br), 64'h0);
    chk("t3_pulse", 64'(pl), 64'h0004);
    exp_reg[2] = 32'hDE22BE44;
    check_bank("t3");
    axi_read(32'h08, rd, rr);
    chk("t3_rdata", 64'(rd), 64'hDE22BE44);

    // 4. error decode
    axi_write(32'h40, 32'h12345678, 4'hF, br, pl);
    chk("t4_oor_bresp", 64'(br), 64'h2);
    chk("t4_oor_pulse", 64'(pl), 64'h0);
    axi_write(32'h0C, 32'h87654321, 4'hF, br, pl);
    chk("t4_ro_bresp", 64'(br), 64'h2);
    chk("t4_ro_pulse", 64'(pl), 64'h0);
    check_bank("t4");
    axi_read(32'h40, rd, rr);
    chk("t4_oor_rdata", 64'(rd), 64'h0);
    chk("t4_oor_rresp", 64'(rr), 64'h2);
    axi_read(32'h0E, rd, rr);
    chk("t4_lowbits_rdata", 64'(rd), 64'hCAFE0000);
    chk("t4_lowbits_rresp", 64'(rr), 64'h0);

    // 5. B backpressure with a second write queued
    axi_bready  = 1'b0;
    axi_awaddr  = 32'h04;
    axi_wdata   = 32'hA1A1A1A1;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    chk("t5_awready_held1", 64'(axi_awready), 64'h0);
    chk("t5_wready_held1",  64'(axi_wready),  64'h0);
    axi_awaddr = 32'h10;
    axi_wdata  = 32'hB2B2B2B2;
    tick();
    chk("t5_b1_valid", 64'(axi_bvalid), 64'h1);
    chk("t5_b1_resp",  64'(axi_bresp),  64'h0);
    chk("t5_b1_pulse", 64'(wr_pulse),   64'h0002);
    chk("t5_reg1",     64'(reg_out[1*DW +: DW]), 64'hA1A1A1A1);
    chk("t5_awready_free", 64'(axi_awready), 64'h1);
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    chk("t5_awready_held2", 64'(axi_awready), 64'h0);
    chk("t5_wready_held2",  64'(axi_wready),  64'h0);
    chk("t5_reg4_wait",     64'(reg_out[4*DW +: DW]), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t5_b1_hold%0d", k), 64'(axi_bvalid), 64'h1);
      chk($sformatf("t5_reg4_hold%0d", k), 64'(reg_out[4*DW +: DW]), 64'h0);
    end
    axi_bready = 1'b1;
    tick();
    chk("t5_b1_done", 64'(axi_bvalid), 64'h0);
    chk("t5_reg4_not_yet", 64'(reg_out[4*DW +: DW]), 64'h0);
    tick();
    chk("t5_b2_valid", 64'(axi_bvalid), 64'h1);
    chk("t5_b2_resp",  64'(axi_bresp),  64'h0);
    chk("t5_b2_pulse", 64'(wr_pulse),   64'h0010);
    chk("t5_reg4",     64'(reg_out[4*DW +: DW]), 64'hB2B2B2B2);
    tick();
    axi_bready = 1'b0;
    chk("t5_b2_done", 64'(axi_bvalid), 64'h0);
    exp_reg[1] = 32'hA1A1A1A1;
    exp_reg[4] = 32'hB2B2B2B2;
    check_bank("t5");

    // AR on the same edge as a commit to the same register sees the old value
    axi_awaddr  = 32'h18;
    axi_wdata   = 32'h00000099;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_araddr  = 32'h18;
    axi_arvalid = 1'b1;
    tick();
    axi_arvalid = 1'b0;
    axi_rready  = 1'b1;
    axi_bready  = 1'b1;
    got = 1'b0;
    rd  = 'x;
    c   = 0;
    while (!got && c < 20) begin
      if (axi_rvalid) begin got = 1'b1; rd = axi_rdata; end
      tick();
      c++;
    end
    axi_rready = 1'b0;
    axi_bready = 1'b0;
    chk("t7_rvalid_seen", 64'(got), 64'h1);
    chk("t7_prewrite_rdata", 64'(rd), 64'h0);
    exp_reg[6] = 32'h00000099;
    chk("t7_reg6", 64'(reg_out[6*DW +: DW]), 64'h99);

    // 6. reset while both B and R are pending
    axi_awaddr  = 32'h14;
    axi_wdata   = 32'h00000077;
    axi_wstrb   = 4'hF;
    axi_awvalid = 1'b1;
    axi_wvalid  = 1'b1;
    axi_araddr  = 32'h08;
    axi_arvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_arvalid = 1'b0;
    tick();
    chk("t6_bvalid_pre", 64'(axi_bvalid), 64'h1);
    chk("t6_rvalid_pre", 64'(axi_rvalid), 64'h1);
    chk("t6_rdata_pre",  64'(axi_rdata),  64'hDE22BE44);
    chk("t6_reg5_pre",   64'(reg_out[5*DW +: DW]), 64'h77);
    chk("t6_pulse_pre",  64'(wr_pulse),   64'h0020);
    #2 resetn = 1'b0;
    #1;
    chk("t6_bvalid",   64'(axi_bvalid),  64'h0);
    chk("t6_rvalid",   64'(axi_rvalid),  64'h0);
    chk("t6_awready",  64'(axi_awready), 64'h1);
    chk("t6_wready",   64'(axi_wready),  64'h1);
    chk("t6_arready",  64'(axi_arready), 64'h1);
    chk("t6_wr_pulse", 64'(wr_pulse),    64'h0);
    chk("t6_rdata",    64'(axi_rdata),   64'h0);
    for (int i = 0; i < NR; i++) exp_reg[i] = '0;
    check_bank("t6");
    tick();
    resetn = 1'b1;
    tick();
    axi_read(32'h08, rd, rr);
    chk("t6_post_rdata", 64'(rd), 64'h0);
    chk("t6_post_rresp", 64'(rr), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
